// File: rtl/parking_fee_unit_if.sv
// Payment-station bus of the parking fee unit: event pulses in, payment status out.
// The fee unit is the slave; the pay-station controller or bench is the master.
interface parking_fee_unit_if #(
  parameter int W = 8
);
  logic         start;
  logic         ticket;
  logic         coin_valid;
  logic [W-1:0] coin_val;
  logic         clear;
  logic [1:0]   P;
  logic [W-1:0] fee;
  logic [W-1:0] paid;
  logic [W-1:0] change;
  logic         busy;

  modport master (
    output start, ticket, coin_valid, coin_val, clear,
    input  P, fee, paid, change, busy
  );

  modport slave (
    input  start, ticket, coin_valid, coin_val, clear,
    output P, fee, paid, change, busy
  );
endinterface

// File: rtl/parking_fee_unit.sv
// Parking fee unit: times a stay, latches the fee at ticket, accumulates coins
// against it and reports the payment code P plus change due.
module parking_fee_unit #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned RATE      = 5,
  parameter int unsigned MIN_FEE   = 5,
  parameter int unsigned MAX_UNITS = 99,
  parameter int unsigned W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  parking_fee_unit_if.slave bus
);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned UW = (MAX_UNITS > 0) ? $clog2(MAX_UNITS + 1) : 1;
  localparam int unsigned FW = UW + 32;
  localparam logic [W-1:0] FULL = {W{1'b1}};

  typedef enum logic [1:0] {IDLE, TIMING, COLLECT, DONE} state_t;

  state_t         state, state_nxt;
  logic [PW-1:0]  presc;
  logic [UW-1:0]  units;
  logic [W-1:0]   fee_r;
  logic [W-1:0]   paid_r;
  logic [W-1:0]   paid_sum;
  logic           wrap;
  logic           wipe;

  // Fee is formed at full product width so a large RATE cannot wrap before saturating.
  function automatic logic [W-1:0] fee_of(input logic [UW-1:0] u);
    logic [FW-1:0] prod;
    prod = FW'(u) * FW'(RATE);
    if (prod < FW'(MIN_FEE)) prod = FW'(MIN_FEE);
    if (prod > FW'(FULL)) return FULL;
    return prod[W-1:0];
  endfunction

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W] ? FULL : s[W-1:0];
  endfunction

  assign paid_sum = sat_add(paid_r, bus.coin_val);
  assign wrap     = (presc == PW'(TICK_DIV - 1));
  // A fresh start and any clear both begin from an empty transaction.
  assign wipe     = (state == IDLE) ? bus.start : bus.clear;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = TIMING;
      TIMING: begin
        if (bus.clear)       state_nxt = IDLE;
        else if (bus.ticket) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (bus.clear)                                state_nxt = IDLE;
        else if (bus.coin_valid && paid_sum >= fee_r) state_nxt = DONE;
      end
      DONE:    if (bus.clear) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || wipe) begin
      presc  <= '0;
      units  <= '0;
      fee_r  <= '0;
      paid_r <= '0;
    end else begin
      unique case (state)
        TIMING: begin
          // Ticket freezes time, so a coincident wrap never reaches the fee.
          if (bus.ticket) begin
            fee_r <= fee_of(units);
          end else if (wrap) begin
            presc <= '0;
            if (units != UW'(MAX_UNITS)) units <= units + UW'(1);
          end else begin
            presc <= presc + PW'(1);
          end
        end
        COLLECT: if (bus.coin_valid) paid_r <= paid_sum;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.P = 2'b00;
    unique case (state)
      COLLECT: bus.P = 2'b01;
      DONE:    bus.P = (paid_r == fee_r) ? 2'b10 : 2'b11;
      default: bus.P = 2'b00;
    endcase
  end

  assign bus.fee    = fee_r;
  assign bus.paid   = paid_r;
  assign bus.busy   = (state != IDLE);
  assign bus.change = (state == DONE && paid_r > fee_r) ? paid_r - fee_r : '0;
endmodule

// File: doc/parking_fee_unit.md
Name: parking_fee_unit

Overview:
Upstream stage of the parking payment FSM; it produces the 2-bit payment code P[1:0] that the payment FSM consumes.
- Measures how long a vehicle has been parked, from the entry event until the ticket is presented.
- Converts that time into a fee and accumulates debounced coin inputs against the fee.
- Reports the payment status on P[1:0] and the change due.
- Fully synchronous: one clock domain, no combinational path from inputs to outputs.

Parameters:
TICK_DIV, 50000000, clk cycles per billed time unit (>=1)
RATE, 5, currency units charged per time unit
MIN_FEE, 5, minimum fee charged, even for zero elapsed units
MAX_UNITS, 99, time-unit counter saturation value (caps the fee)
W, 8, width of fee/paid/change amounts

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: vehicle entered, begin timing
ticket  in  1  one-cycle pulse: driver at pay station, freeze time and latch fee
coin_valid  in  1  one-cycle pulse, already debounced: a coin was inserted
coin_val  in  W  value of the inserted coin, sampled when coin_valid=1
clear  in  1  one-cycle pulse: payment acknowledged or transaction aborted, return to IDLE
P  out  2  payment code: 00 idle/timing, 01 insufficient, 10 exact, 11 overpaid
fee  out  W  latched fee for the current transaction
paid  out  W  accumulated coin total
change  out  W  paid-fee when P=11, else 0
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset: rst is sampled on the rising clk edge and overrides all other inputs. State becomes IDLE and the prescaler, units, fee, paid and change all go to 0; P=00, busy=0.
- States: IDLE, TIMING, COLLECT, DONE. All outputs are registered or decoded from registers only.
- IDLE:
  - start=1: go to TIMING; prescaler=0, units=0, paid=0, fee=0.
  - ticket, coin_valid and clear are ignored.
- TIMING:
  - The prescaler counts 0..TICK_DIV-1. On wrap, units increments, saturating at MAX_UNITS.
  - ticket=1: go to COLLECT; fee <= max(MIN_FEE, units*RATE). The product is computed at full width, then saturated to 2^W-1.
  - If a prescaler wrap and ticket land in the same cycle, fee uses the pre-increment units value.
  - start is ignored; coins are ignored.
- COLLECT:
  - coin_valid=1: paid <= sat(paid+coin_val), saturating at 2^W-1. A coin of value 0 is accepted with no effect.
  - If sat(paid+coin_val) >= fee, go to DONE on the same edge.
  - P=01 throughout COLLECT.
- DONE:
  - P=10 if paid==fee, P=11 if paid>fee; change=paid-fee when P=11, else 0.
  - Further coins are ignored; paid is frozen. Ticket and start are ignored.
- clear=1 in any non-IDLE state: next state IDLE, paid/fee/change/units cleared, P=00. This is also the abort path from TIMING or COLLECT.
- Latency:
  - A coin pulse in cycle n is reflected in paid and P in cycle n+1.
  - ticket in cycle n gives fee valid and P=01 in cycle n+1.
- Precedence within a cycle: rst > clear > ticket/coin > start.
- Simultaneous start+clear in a non-IDLE state: clear wins and start is dropped, so a new start pulse is required.

Test Plan:
1. Reset: hold rst high 2 cycles with random inputs toggling -> P=00, fee=paid=change=0, busy=0. Release; start -> busy=1 next cycle.
2. Exact pay (TICK_DIV=4, RATE=5, MIN_FEE=5, W=8): start, wait 12 cycles, ticket -> fee=15, P=01. Coins 10 then 5 -> paid=10/P=01, then paid=15/P=10, change=0.
3. Overpay and frozen DONE: same fee 15; coins 10,10 -> P=11, change=5. Extra coin 10 -> paid stays 20, P stays 11. clear -> P=00, busy=0.
4. Boundaries: ticket 2 cycles after start -> fee=5 (MIN_FEE). Ticket on the prescaler-wrap cycle at units=2 -> fee=10, not 15. With MAX_UNITS=2, wait 5 units -> fee=10.
5. Saturation: RATE=100, 3 units -> fee=255. Coins 200, 200 -> paid=255, P=10, change=0.
6. Abort: clear in COLLECT with paid=10 -> next cycle IDLE, paid=0, P=00. rst mid-TIMING -> units=0, IDLE. Start in COLLECT is ignored; state unchanged.
